// File: rtl/mux_arb_2x1_pkg.sv
// Shared types and constants for the 2:1 round-robin operand select arbiter.
package mux_arb_2x1_pkg;
  localparam int DATA_W_DEF = 8;

  typedef logic src_t;

  localparam src_t SRC_A = 1'b0;
  localparam src_t SRC_B = 1'b1;
endpackage

// File: rtl/mux_arb_2x1_rr_pick_2.sv
// Two-way round-robin pick: a lone requester wins, ties go to the source that did not win last.
module rr_pick_2
  import mux_arb_2x1_pkg::*;
(
  input  logic [1:0] valid,
  input  src_t       last_src,
  output src_t       grant,
  output logic       any_valid
);
  always_comb begin
    grant = src_t'(~last_src);
    if (valid == 2'b01)      grant = SRC_A;
    else if (valid == 2'b10) grant = SRC_B;
  end

  assign any_valid = |valid;
endmodule

// File: rtl/mux_arb_2x1.sv
// Round-robin 2:1 byte select with a single-entry output register and valid/ready on all sides.
// Optional per-source saturating transfer counters under MUX_ARB_STATS_EN.
module mux_arb_2x1
  import mux_arb_2x1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output src_t              out_src,
  input  logic              out_ready,
  output src_t              sel,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);
  src_t last_src;
  src_t grant;
  logic any_valid;
  logic load;

  rr_pick_2 u_pick (
    .valid     ({b_valid, a_valid}),
    .last_src  (last_src),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // Register accepts when empty or being drained in the same cycle.
  assign load    = ~out_valid | out_ready;
  assign sel     = grant;
  assign a_ready = load & a_valid & (grant == SRC_A);
  assign b_ready = load & b_valid & (grant == SRC_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_A;
      last_src  <= SRC_B;
    end else if (load) begin
      if (any_valid) begin
        out_data  <= sel ? b_data : a_data;
        out_src   <= grant;
        out_valid <= 1'b1;
        last_src  <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (a_ready && cnt_a_q != '1) cnt_a_q <= cnt_a_q + 1'b1;
      if (b_ready && cnt_b_q != '1) cnt_b_q <= cnt_b_q + 1'b1;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`else
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif
endmodule
